snake_game_ctrl: RTL and testbench

- Game sequencer for the 4x4 playfield of the 6x6 LED matrix.
- Owns the head position and apple position that feed the matrix renderer.
- Advances the head one cell per movement tick in the latched direction, detects apple capture, wall collision and win, and relocates the apple pseudo-randomly.
- Sits between the button/timer logic and the LED matrix block.

---
 rtl/snake_pkg.sv | 35 +++
 rtl/snake_lfsr.sv | 28 ++
 rtl/snake_game_ctrl.sv | 154 +++++++++++++++
 tb/tb_snake_game_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared encodings for the snake game sequencer: FSM states, direction codes,
// cell field positions and default start cells.
package snake_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PLAY     = 3'd1,
        ST_RELOCATE = 3'd2,
        ST_OVER     = 3'd3,
        ST_WIN      = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    // Cell encoding is {row[1:0], col[1:0]}
    localparam int ROW_MSB = 3;
    localparam int ROW_LSB = 2;
    localparam int COL_MSB = 1;
    localparam int COL_LSB = 0;

    localparam logic [3:0] DEF_START_POS   = 4'd5;
    localparam logic [3:0] DEF_START_APPLE = 4'd10;
    localparam logic [3:0] DEF_MAX_SCORE   = 4'd15;

    // Opposite directions differ only in bit 1
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a ^ b) == 2'b10;
    endfunction

endpackage

// File: rtl/snake_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to pick apple cells; never reaches zero.
// Latency: new value every clock; no backpressure, free-running in every state.
module snake_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] value
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer for the 4x4 playfield: head/apple/score tracking, capture, wall, win.
// Latency: 1 cycle tick-to-position; no backpressure. SNAKE_WRAP_EN makes edges wrap (no OVER).
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter logic [7:0] SEED        = 8'hA5,
    parameter logic [3:0] START_POS   = DEF_START_POS,
    parameter logic [3:0] START_APPLE = DEF_START_APPLE,
    parameter logic [3:0] MAX_SCORE   = DEF_MAX_SCORE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       tick,
    input  logic       dir_valid,
    input  logic [1:0] dir,
    output logic [3:0] position,
    output logic [3:0] apple,
    output logic [3:0] score,
    output logic       playing,
    output logic       game_over,
    output logic       win
);

    state_e     state_q, state_d;
    dir_e       dir_q, dir_d;
    logic [3:0] pos_q, pos_d;
    logic [3:0] apple_q, apple_d;
    logic [3:0] score_q, score_d;
    logic       playing_q, playing_d;
    logic       over_q, over_d;
    logic       win_q, win_d;

    logic [3:0] lfsr_unused;
    logic [3:0] candidate;
    logic [1:0] row, col, next_row, next_col;
    logic [3:0] next_cell;
    logic       hit_wall;

    snake_lfsr #(.SEED(SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .value ({lfsr_unused, candidate})
    );

    // Next head cell always follows the direction held before this edge
    always_comb begin
        row      = pos_q[ROW_MSB:ROW_LSB];
        col      = pos_q[COL_MSB:COL_LSB];
        next_row = row;
        next_col = col;
        case (dir_q)
            DIR_UP:    next_row = row - 2'd1;
            DIR_RIGHT: next_col = col + 2'd1;
            DIR_DOWN:  next_row = row + 2'd1;
            default:   next_col = col - 2'd1;
        endcase
`ifdef SNAKE_WRAP_EN
        hit_wall = 1'b0;
`else
        case (dir_q)
            DIR_UP:    hit_wall = (row == 2'd0);
            DIR_RIGHT: hit_wall = (col == 2'd3);
            DIR_DOWN:  hit_wall = (row == 2'd3);
            default:   hit_wall = (col == 2'd0);
        endcase
`endif
    end

    assign next_cell = {next_row, next_col};

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        apple_d = apple_q;
        score_d = score_q;

        if ((state_q == ST_PLAY || state_q == ST_RELOCATE) && dir_valid
                && !is_reverse(dir, dir_q)) begin
            dir_d = dir_e'(dir);
        end

        case (state_q)
            ST_IDLE: begin
                if (iniciar) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (tick) begin
                    if (hit_wall) begin
                        state_d = ST_OVER;
                    end else begin
                        pos_d = next_cell;
                        if (next_cell == apple_q) begin
                            score_d = score_q + 4'd1;
                            state_d = (score_d == MAX_SCORE) ? ST_WIN : ST_RELOCATE;
                        end
                    end
                end
            end
            ST_RELOCATE: begin
                // Retry on later cycles if the LFSR lands on the head
                if (candidate != pos_q) begin
                    apple_d = candidate;
                    state_d = ST_PLAY;
                end
            end
            ST_OVER, ST_WIN: begin
                if (iniciar) begin
                    pos_d   = START_POS;
                    apple_d = START_APPLE;
                    score_d = 4'd0;
                    dir_d   = DIR_RIGHT;
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        playing_d = (state_d == ST_PLAY) || (state_d == ST_RELOCATE);
        over_d    = (state_d == ST_OVER);
        win_d     = (state_d == ST_WIN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_RIGHT;
            pos_q     <= START_POS;
            apple_q   <= START_APPLE;
            score_q   <= 4'd0;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            pos_q     <= pos_d;
            apple_q   <= apple_d;
            score_q   <= score_d;
            playing_q <= playing_d;
            over_q    <= over_d;
            win_q     <= win_d;
        end
    end

    assign position  = pos_q;
    assign apple     = apple_q;
    assign score     = score_q;
    assign playing   = playing_q;
    assign game_over = over_q;
    assign win       = win_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl: driver pushes expected outputs, monitor pops and compares.
`timescale 1ns/1ps
module tb_snake_game_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       tick = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir = 2'b00;
    logic [3:0] position, apple, score;
    logic       playing, game_over, win;

    snake_game_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .tick      (tick),
        .dir_valid (dir_valid),
        .dir       (dir),
        .position  (position),
        .apple     (apple),
        .score     (score),
        .playing   (playing),
        .game_over (game_over),
        .win       (win)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] pos;
        logic [3:0] apple;
        logic [3:0] score;
        logic [2:0] flags;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam int M_IDLE = 0, M_PLAY = 1, M_RELOC = 2, M_OVER = 3, M_WIN = 4;
    int         m_st;
    logic [3:0] m_pos, m_apple, m_score;
    logic [1:0] m_dir;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded 8'hA5 on reset
    logic [7:0] lfsr_m;
    always @(posedge clock) begin
        if (reset) lfsr_m <= 8'hA5;
        else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    task automatic chk(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk(e.name, "position", position, e.pos);
                chk(e.name, "apple", apple, e.apple);
                chk(e.name, "score", score, e.score);
                chk(e.name, "flags", {1'b0, playing, game_over, win}, {1'b0, e.flags});
            end
        end
    end

    task automatic bound_fail(input string nm);
        n_checks++;
        $display("FAIL %s: cycle budget expired", nm);
    endtask

    // Drive one cycle of inputs and push the outputs expected after the next edge
    task automatic step(input logic rs, input logic ini, input logic tk, input logic dv,
                        input logic [1:0] d, input string nm);
        exp_t       e;
        logic [1:0] old_dir, r, c;
        @(negedge clock);
        reset = rs; iniciar = ini; tick = tk; dir_valid = dv; dir = d;
        old_dir = m_dir;
        if (rs) begin
            m_st = M_IDLE; m_pos = 4'd5; m_apple = 4'd10; m_score = 4'd0; m_dir = 2'b01;
        end else begin
            case (m_st)
                M_IDLE: if (ini) m_st = M_PLAY;
                M_PLAY, M_RELOC: begin
                    if (dv && d != (m_dir ^ 2'b10)) m_dir = d;
                    if (m_st == M_PLAY && tk) begin
                        r = m_pos[3:2];
                        c = m_pos[1:0];
`ifndef SNAKE_WRAP_EN
                        if ((old_dir == 2'd0 && r == 2'd0) || (old_dir == 2'd1 && c == 2'd3) ||
                            (old_dir == 2'd2 && r == 2'd3) || (old_dir == 2'd3 && c == 2'd0))
                            m_st = M_OVER;
`endif
                        case (old_dir)
                            2'd0:    r = r - 2'd1;
                            2'd1:    c = c + 2'd1;
                            2'd2:    r = r + 2'd1;
                            default: c = c - 2'd1;
                        endcase
                        if (m_st == M_PLAY) begin
                            m_pos = {r, c};
                            if (m_pos == m_apple) begin
                                m_score = m_score + 4'd1;
                                m_st = (m_score == 4'd15) ? M_WIN : M_RELOC;
                            end
                        end
                    end else if (m_st == M_RELOC && lfsr_m[3:0] != m_pos) begin
                        m_apple = lfsr_m[3:0];
                        m_st = M_PLAY;
                    end
                end
                default: if (ini) begin
                    m_st = M_PLAY; m_pos = 4'd5; m_apple = 4'd10; m_score = 4'd0; m_dir = 2'b01;
                end
            endcase
        end
        e.pos   = m_pos;
        e.apple = m_apple;
        e.score = m_score;
        e.flags = {(m_st == M_PLAY || m_st == M_RELOC), (m_st == M_OVER), (m_st == M_WIN)};
        e.name  = nm;
        sb_q.push_back(e);
    endtask

    task automatic settle(input string nm);
        for (int k = 0; k < 8 && m_st == M_RELOC; k++) step(0, 0, 0, 0, 2'b00, nm);
        if (m_st == M_RELOC) bound_fail(nm);
    endtask

    task automatic restart(input string nm);
        step(1, 0, 0, 0, 2'b00, {nm, "_rst"});
        step(0, 1, 0, 0, 2'b00, {nm, "_start"});
    endtask

    // Walk the head to the apple: rows first, then columns; reversals go via a perpendicular
    task automatic go_to_apple(input string nm);
        logic [1:0] want;
        for (int n = 0; n < 8 && m_st == M_PLAY; n++) begin
            if (m_pos[3:2] < m_apple[3:2])      want = 2'b10;
            else if (m_pos[3:2] > m_apple[3:2]) want = 2'b00;
            else if (m_pos[1:0] < m_apple[1:0]) want = 2'b01;
            else                                want = 2'b11;
            if (want != m_dir) begin
                if (want == (m_dir ^ 2'b10)) step(0, 0, 0, 1, want ^ 2'b01, {nm, "_turn"});
                step(0, 0, 0, 1, want, {nm, "_dir"});
            end
            step(0, 0, 1, 0, 2'b00, {nm, "_move"});
        end
    endtask

    initial begin : driver
        // Reset, idle inputs ignored, then straight run to the right wall
        step(1, 0, 0, 0, 2'b00, "reset");
        step(0, 0, 1, 0, 2'b00, "idle_tick");
        step(0, 0, 0, 1, 2'b10, "idle_dir");
        step(0, 1, 0, 0, 2'b00, "start");
        step(0, 0, 1, 0, 2'b00, "tick_pos6");
        step(0, 0, 1, 0, 2'b00, "tick_pos7");
        step(0, 0, 1, 0, 2'b00, "tick_wall");
`ifndef SNAKE_WRAP_EN
        step(0, 0, 1, 0, 2'b00, "over_frozen");
        step(0, 1, 0, 0, 2'b00, "restart_over");
`endif
        // Turn down, turn right, capture the start apple
        restart("cap");
        step(0, 0, 0, 1, 2'b10, "cap_dir_down");
        step(0, 0, 1, 0, 2'b00, "cap_pos9");
        step(0, 0, 0, 1, 2'b01, "cap_dir_right");
        step(0, 0, 1, 0, 2'b00, "cap_capture");
        settle("cap_reloc");
        // Reverse request dropped
        restart("rev");
        step(0, 0, 0, 1, 2'b11, "rev_drop");
        step(0, 0, 1, 0, 2'b00, "rev_tick");
        // Direction and tick together: old direction moves, new one next
        restart("coin");
        step(0, 0, 1, 1, 2'b10, "coin_same");
        step(0, 0, 1, 0, 2'b00, "coin_next");
        settle("coin_reloc");
        // Reset while relocating
        restart("rr");
        step(0, 0, 0, 1, 2'b10, "rr_dir");
        step(0, 0, 1, 0, 2'b00, "rr_pos9");
        step(0, 0, 0, 1, 2'b01, "rr_dir2");
        step(0, 0, 1, 0, 2'b00, "rr_capture");
        step(1, 0, 0, 0, 2'b00, "rr_reset");
        step(0, 0, 1, 0, 2'b00, "rr_idle_tick");
        // Eat up to the winning score
        restart("win");
        for (int g = 0; g < 20 && m_st != M_WIN; g++) begin
            go_to_apple("win");
            settle("win_reloc");
        end
        if (m_st != M_WIN) bound_fail("win_reach");
        step(0, 0, 1, 0, 2'b00, "win_frozen1");
        step(0, 0, 1, 1, 2'b10, "win_frozen2");
        step(0, 1, 0, 0, 2'b00, "restart_win");
        repeat (3) @(negedge clock);
        if (sb_q.size() != 0) bound_fail("scoreboard_drain");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
